// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm beeper: FSM state encoding, default cycle
// constants and small helpers for sizing the down-counters.
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEEP  = 2'd1,
        ST_GAP   = 2'd2,
        ST_PAUSE = 2'd3
    } alarm_state_e;

    localparam int unsigned TONE_HALF_DEF = 25000;
    localparam int unsigned BEEP_CYC_DEF  = 25000000;
    localparam int unsigned GAP_CYC_DEF   = 25000000;
    localparam int unsigned PAUSE_CYC_DEF = 100000000;
    localparam int unsigned BURST_N_DEF   = 4;
    localparam int unsigned BURST_MAX     = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold the values 0 .. n-1 (a down-counter reloaded with n-1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (clears both flops)
//   d      in  asynchronous level
//   q      out synchronized level, two clk edges behind d
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/alarm_beeper.sv
// -----------------------------------------------------------------------------
// alarm_beeper
// Drives a piezo with bursts of square-wave beeps while the alarm level is high.
// A burst is a number of beeps separated by silent gaps, followed by a long pause.
//
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   alarming   in  alarm level from another clock domain
//   buzzer     out registered square-wave drive
//   beeping    out high whenever the FSM is not IDLE
//   burst_cnt  out completed bursts since the alarm started, saturating at 255
//
// Build option:
//   ALARM_BEEPER_ESCALATE_EN  each burst gets one more beep than the previous,
//                             up to 8 (limit = min(BURST_N + burst_cnt, 8)).
//
// state | meaning
// IDLE  | alarm not active, outputs silent
// BEEP  | tone playing, buzzer toggling every TONE_HALF cycles
// GAP   | silence between beeps of one burst
// PAUSE | silence after a complete burst
// -----------------------------------------------------------------------------
module alarm_beeper
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_HALF = TONE_HALF_DEF,
    parameter int unsigned BEEP_CYC  = BEEP_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned PAUSE_CYC = PAUSE_CYC_DEF,
    parameter int unsigned BURST_N   = BURST_N_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarming,
    output logic       buzzer,
    output logic       beeping,
    output logic [7:0] burst_cnt
);

    localparam int unsigned PH_W = cnt_width(max3(BEEP_CYC, GAP_CYC, PAUSE_CYC));
    localparam int unsigned TN_W = cnt_width(TONE_HALF);

    localparam logic [PH_W-1:0] PH_BEEP   = PH_W'(BEEP_CYC - 1);
    localparam logic [PH_W-1:0] PH_GAP    = PH_W'(GAP_CYC - 1);
    localparam logic [PH_W-1:0] PH_PAUSE  = PH_W'(PAUSE_CYC - 1);
    localparam logic [TN_W-1:0] TN_RELOAD = TN_W'(TONE_HALF - 1);

    logic            alarm_s;
    alarm_state_e    state_q;
    logic            buzzer_q;
    logic            beeping_q;
    logic [7:0]      burst_cnt_q;
    logic [2:0]      idx_q;
    logic [PH_W-1:0] phase_q;
    logic [TN_W-1:0] tone_q;
    logic [3:0]      limit_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (alarming),
        .q     (alarm_s)
    );

`ifdef ALARM_BEEPER_ESCALATE_EN
    logic [8:0] lim_sum;
    assign lim_sum = 9'(BURST_N) + {1'b0, burst_cnt_q};
    assign limit_d = (lim_sum > 9'(BURST_MAX)) ? 4'(BURST_MAX) : lim_sum[3:0];
`else
    assign limit_d = 4'(BURST_N);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            buzzer_q    <= 1'b0;
            beeping_q   <= 1'b0;
            burst_cnt_q <= 8'd0;
            idx_q       <= 3'd0;
            phase_q     <= '0;
            tone_q      <= '0;
        end else if (!alarm_s) begin
            // burst_cnt is deliberately kept so software can read it after the alarm ends
            state_q   <= ST_IDLE;
            buzzer_q  <= 1'b0;
            beeping_q <= 1'b0;
            idx_q     <= 3'd0;
            phase_q   <= '0;
            tone_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_BEEP;
                    buzzer_q    <= 1'b1;
                    beeping_q   <= 1'b1;
                    burst_cnt_q <= 8'd0;
                    idx_q       <= 3'd0;
                    phase_q     <= PH_BEEP;
                    tone_q      <= TN_RELOAD;
                end
                ST_BEEP: begin
                    if (phase_q == '0) begin
                        state_q  <= ST_GAP;
                        buzzer_q <= 1'b0;
                        phase_q  <= PH_GAP;
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                        if (tone_q == '0) begin
                            buzzer_q <= ~buzzer_q;
                            tone_q   <= TN_RELOAD;
                        end else begin
                            tone_q <= tone_q - TN_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (phase_q == '0) begin
                        if ((4'(idx_q) + 4'd1) < limit_d) begin
                            state_q  <= ST_BEEP;
                            buzzer_q <= 1'b1;
                            idx_q    <= idx_q + 3'd1;
                            phase_q  <= PH_BEEP;
                            tone_q   <= TN_RELOAD;
                        end else begin
                            state_q <= ST_PAUSE;
                            phase_q <= PH_PAUSE;
                            if (burst_cnt_q != 8'hFF) begin
                                burst_cnt_q <= burst_cnt_q + 8'd1;
                            end
                        end
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (phase_q == '0) begin
                        state_q  <= ST_BEEP;
                        buzzer_q <= 1'b1;
                        idx_q    <= 3'd0;
                        phase_q  <= PH_BEEP;
                        tone_q   <= TN_RELOAD;
                    end else begin
                        phase_q <= phase_q - PH_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    buzzer_q  <= 1'b0;
                    beeping_q <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer    = buzzer_q;
    assign beeping   = beeping_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_alarm_beeper.sv
module tb_alarm_beeper;

    logic       clk;
    logic       rst_n;
    logic       alarming;
    logic       buzzer;
    logic       beeping;
    logic [7:0] burst_cnt;

    int n_checks;
    int n_fail;

    alarm_beeper #(
        .TONE_HALF (2),
        .BEEP_CYC  (8),
        .GAP_CYC   (4),
        .PAUSE_CYC (12),
        .BURST_N   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarming  (alarming),
        .buzzer    (buzzer),
        .beeping   (beeping),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b1;
        alarming = 1'b0;
        #1;
        rst_n = 1'b0;
        #20;
        n_checks++;
        if ({buzzer, beeping, burst_cnt} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: buzzer=%b beeping=%b burst_cnt=%0d, want 0 0 0",
                     buzzer, beeping, burst_cnt);
        end
        step;
        rst_n = 1'b1;
        step;
        step;
        n_checks++;
        if ({buzzer, beeping} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: buzzer=%b beeping=%b, want 0 0", buzzer, beeping);
        end
    endtask

    // Plays one beep plus its gap: 1,1,0,0,1,1,0,0 then 0 x4, beeping high throughout
    task automatic check_beep_gap(input string tag);
        logic [11:0] pat;
        pat = 12'b1100_1100_0000;
        for (int i = 0; i < 12; i++) begin
            step;
            n_checks++;
            if ({buzzer, beeping} !== {pat[11-i], 1'b1}) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: buzzer=%b beeping=%b, want %b 1",
                         tag, i, buzzer, beeping, pat[11-i]);
            end
        end
    endtask

    task automatic test_start;
        logic [11:0] pat;
        pat = 12'b1100_1100_0000;
        alarming = 1'b1;
        step;
        n_checks++;
        if ({buzzer, beeping} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_edge1: buzzer=%b beeping=%b, want 0 0", buzzer, beeping);
        end
        step;
        n_checks++;
        if ({buzzer, beeping} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_edge2: buzzer=%b beeping=%b, want 0 0", buzzer, beeping);
        end
        for (int i = 0; i < 12; i++) begin
            step;
            n_checks++;
            if ({buzzer, beeping} !== {pat[11-i], 1'b1}) begin
                n_fail++;
                $display("FAIL start_beep1_cycle%0d: buzzer=%b beeping=%b, want %b 1",
                         i, buzzer, beeping, pat[11-i]);
            end
            if (i == 0) begin
                n_checks++;
                if (burst_cnt !== 8'd0) begin
                    n_fail++;
                    $display("FAIL start_burst_cnt: got %0d want 0", burst_cnt);
                end
            end
        end
    endtask

    task automatic test_burst;
        logic quiet_ok;
        check_beep_gap("burst_beep2");
        n_checks++;
        if (burst_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL burst_cnt_before_pause: got %0d want 0", burst_cnt);
        end
        step;
        n_checks++;
        if ({buzzer, beeping, burst_cnt} !== {2'b01, 8'd1}) begin
            n_fail++;
            $display("FAIL pause_entry: buzzer=%b beeping=%b burst_cnt=%0d, want 0 1 1",
                     buzzer, beeping, burst_cnt);
        end
        quiet_ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step;
            if ({buzzer, beeping} !== 2'b01) quiet_ok = 1'b0;
        end
        n_checks++;
        if (quiet_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_silent: got %b want 1", quiet_ok);
        end
        step;
        n_checks++;
        if ({buzzer, beeping} !== 2'b11) begin
            n_fail++;
            $display("FAIL pause_resume: buzzer=%b beeping=%b, want 1 1", buzzer, beeping);
        end
    endtask

    task automatic test_escalate;
        int highs;
        int exp_beeps;
        logic done;
`ifdef ALARM_BEEPER_ESCALATE_EN
        exp_beeps = 3;
`else
        exp_beeps = 2;
`endif
        highs = 1;
        done  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step;
            if (burst_cnt == 8'd2) done = 1'b1;
            else if (buzzer === 1'b1) highs++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL escalate_timeout: burst_cnt=%0d want 2", burst_cnt);
        end
        n_checks++;
        if (highs / 4 !== exp_beeps) begin
            n_fail++;
            $display("FAIL escalate_beeps: got %0d want %0d", highs / 4, exp_beeps);
        end
    endtask

    task automatic wait_buzzer_high(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step;
            if (buzzer === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait_beep: buzzer=%b want 1", tag, buzzer);
        end
    endtask

    task automatic test_off_mid_beep;
        wait_buzzer_high("off");
        step;
        alarming = 1'b0;
        step;
        step;
        n_checks++;
        if (beeping !== 1'b1) begin
            n_fail++;
            $display("FAIL off_edge2: beeping=%b want 1", beeping);
        end
        step;
        n_checks++;
        if ({buzzer, beeping, burst_cnt} !== {2'b00, 8'd2}) begin
            n_fail++;
            $display("FAIL off_edge3: buzzer=%b beeping=%b burst_cnt=%0d, want 0 0 2",
                     buzzer, beeping, burst_cnt);
        end
        alarming = 1'b1;
        step;
        step;
        n_checks++;
        if (beeping !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_edge2: beeping=%b want 0", beeping);
        end
        step;
        n_checks++;
        if ({buzzer, beeping, burst_cnt} !== {2'b11, 8'd0}) begin
            n_fail++;
            $display("FAIL restart_edge3: buzzer=%b beeping=%b burst_cnt=%0d, want 1 1 0",
                     buzzer, beeping, burst_cnt);
        end
    endtask

    task automatic test_reset_mid_beep;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step;
            if (burst_cnt == 8'd1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_burst: burst_cnt=%0d want 1", burst_cnt);
        end
        wait_buzzer_high("rst");
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({buzzer, beeping, burst_cnt} !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_mid_beep: buzzer=%b beeping=%b burst_cnt=%0d, want 0 0 0",
                     buzzer, beeping, burst_cnt);
        end
        #1;
        rst_n = 1'b1;
        step;
        step;
        n_checks++;
        if (beeping !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_edge2: beeping=%b want 0", beeping);
        end
        step;
        n_checks++;
        if ({buzzer, beeping} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_release_edge3: buzzer=%b beeping=%b, want 1 1", buzzer, beeping);
        end
    endtask

    task automatic test_saturation;
        logic reached;
        logic held;
        reached = 1'b0;
        for (int i = 0; i < 40000 && !reached; i++) begin
            step;
            if (burst_cnt == 8'd255) reached = 1'b1;
        end
        n_checks++;
        if (reached !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_reach: burst_cnt=%0d want 255", burst_cnt);
        end
        held = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step;
            if (burst_cnt !== 8'd255) held = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: burst_cnt=%0d want 255", burst_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_start;
        test_burst;
        test_escalate;
        test_off_mid_beep;
        test_reset_mid_beep;
        test_saturation;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
